spike_rate_encoder: RTL and testbench

Converts a buffered vector of NUM_INPUTS pixel intensities into NUM_INPUTS parallel spike trains over a fixed window of NUM_STEPS timesteps. Sits directly upstream of the integrate-and-fire neuron array: its spike_out bus drives the neurons' spike_in, and its neuron_rst strobe clears neuron potential before each new image. Pixels arrive over a valid/ready stream. A start pulse launches one presentation window.

---
 rtl/spike_rate_encoder_if.sv | 27 ++
 rtl/spike_rate_encoder.sv | 131 +++++++++++++
 tb/tb_spike_rate_encoder.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spike_rate_encoder_if.sv
// Pixel stream in, spike bus out, for spike_rate_encoder.
// Handshake: a pixel moves on a rising clk edge where pixel_valid and pixel_ready are both 1;
// pixel_data must be stable while pixel_valid is 1, and pixel_ready never depends on pixel_valid.
interface spike_rate_encoder_if #(
  parameter int NUM_INPUTS  = 4,
  parameter int PIXEL_WIDTH = 8
);
  logic                   pixel_valid;
  logic                   pixel_ready;
  logic [PIXEL_WIDTH-1:0] pixel_data;
  logic                   start;
  logic                   busy;
  logic [NUM_INPUTS-1:0]  spike_out;
  logic                   spike_valid;
  logic                   neuron_rst;
  logic                   done;

  modport slave (
    input  pixel_valid, pixel_data, start,
    output pixel_ready, busy, spike_out, spike_valid, neuron_rst, done
  );

  modport master (
    output pixel_valid, pixel_data, start,
    input  pixel_ready, busy, spike_out, spike_valid, neuron_rst, done
  );
endinterface

// File: rtl/spike_rate_encoder.sv
// Rate encoder: buffers NUM_INPUTS pixels, then emits NUM_STEPS spike vectors per start.
// Define SPIKE_ENC_DETERMINISTIC_EN for phase-accumulator spikes instead of LFSR comparison.
module spike_rate_encoder #(
  parameter int          NUM_INPUTS  = 4,
  parameter int          PIXEL_WIDTH = 8,
  parameter int          NUM_STEPS   = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  spike_rate_encoder_if.slave bus,
  output logic [2:0]          state_dbg,
  output logic [15:0]         lfsr_dbg
);

  localparam int IDX_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  // Encoding is visible on state_dbg: IDLE=0 LOAD=1 ARMED=2 RUN=3 DONE=4.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ARMED = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q;
  logic [STEP_W-1:0]      step_q;
  logic [15:0]            lfsr_q, lfsr_next;
  logic [PIXEL_WIDTH-1:0] pix_buf [NUM_INPUTS];
  logic [NUM_INPUTS-1:0]  spike_d, spike_q;
  logic                   spike_valid_q, neuron_rst_q, done_q;
  logic                   xfer, last_xfer, launch, last_step, fire;

  assign xfer      = bus.pixel_valid && bus.pixel_ready;
  assign last_xfer = xfer && (idx_q == IDX_W'(NUM_INPUTS - 1));
  assign launch    = (state_q == S_ARMED) && bus.start;
  assign last_step = (step_q == STEP_W'(NUM_STEPS - 1));
  // The first spike is issued on the start edge so it lines up with neuron_rst.
  assign fire      = launch || ((state_q == S_RUN) && !last_step);
  assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    bus.pixel_ready = 1'b0;
    bus.busy        = 1'b1;
    case (state_q)
      S_IDLE: begin
        bus.pixel_ready = 1'b1;
        bus.busy        = 1'b0;
        if (xfer) state_d = last_xfer ? S_ARMED : S_LOAD;
      end
      S_LOAD: begin
        bus.pixel_ready = 1'b1;
        if (last_xfer) state_d = S_ARMED;
      end
      S_ARMED: if (bus.start) state_d = S_RUN;
      S_RUN:   if (last_step) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef SPIKE_ENC_DETERMINISTIC_EN
  logic [PIXEL_WIDTH-1:0] acc_q [NUM_INPUTS];
  logic [PIXEL_WIDTH:0]   sum   [NUM_INPUTS];

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_acc
    assign sum[i]     = {1'b0, launch ? PIXEL_WIDTH'(0) : acc_q[i]} + {1'b0, pix_buf[i]};
    assign spike_d[i] = sum[i][PIXEL_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_INPUTS; i++) acc_q[i] <= '0;
    end else if (fire) begin
      for (int i = 0; i < NUM_INPUTS; i++) acc_q[i] <= sum[i][PIXEL_WIDTH-1:0];
    end
  end
`else
  // Each input sees the LFSR rotated by its index, so inputs are decorrelated per step.
  function automatic logic [PIXEL_WIDTH-1:0] rnd_bits(input logic [15:0] x, input int k);
    return PIXEL_WIDTH'((x << k) | (x >> (16 - k)));
  endfunction

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_cmp
    assign spike_d[i] = rnd_bits(lfsr_q, i % 16) < pix_buf[i];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q         <= '0;
      step_q        <= '0;
      lfsr_q        <= SEED;
      spike_q       <= '0;
      spike_valid_q <= 1'b0;
      neuron_rst_q  <= 1'b0;
      done_q        <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) pix_buf[i] <= '0;
    end else begin
      neuron_rst_q  <= launch;
      done_q        <= (state_q == S_RUN) && last_step;
      spike_valid_q <= fire;
      spike_q       <= fire ? spike_d : '0;
      if (xfer) idx_q <= last_xfer ? '0 : idx_q + IDX_W'(1);
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (xfer && (idx_q == IDX_W'(i))) pix_buf[i] <= bus.pixel_data;
      end
      if (launch)                                step_q <= '0;
      else if ((state_q == S_RUN) && !last_step) step_q <= step_q + STEP_W'(1);
      if (fire) lfsr_q <= lfsr_next;
    end
  end

  assign bus.spike_out   = spike_q;
  assign bus.spike_valid = spike_valid_q;
  assign bus.neuron_rst  = neuron_rst_q;
  assign bus.done        = done_q;
  assign state_dbg       = state_q;
  assign lfsr_dbg        = lfsr_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Bench for spike_rate_encoder: random images against a spec-level spike model, plus
// protocol timing, reset, back-pressure, statistics and a NUM_INPUTS=1 period check.
module tb_spike_rate_encoder;
  localparam int NI = 4;
  localparam int PW = 8;
  localparam int NS = 16;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_ARMED = 3'd2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spike_rate_encoder_if #(.NUM_INPUTS(NI), .PIXEL_WIDTH(PW)) bus ();
  spike_rate_encoder_if #(.NUM_INPUTS(1),  .PIXEL_WIDTH(PW)) bus1 ();
  logic [2:0]  state_dbg, state_dbg1;
  logic [15:0] lfsr_dbg, lfsr_dbg1;

  spike_rate_encoder #(.NUM_INPUTS(NI), .PIXEL_WIDTH(PW), .NUM_STEPS(NS), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg), .lfsr_dbg(lfsr_dbg)
  );

  spike_rate_encoder #(.NUM_INPUTS(1), .PIXEL_WIDTH(PW), .NUM_STEPS(NS), .LFSR_SEED(SEED)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .state_dbg(state_dbg1), .lfsr_dbg(lfsr_dbg1)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0]   m_lfsr;
  logic [PW-1:0] m_pix [NI];
  logic [NI-1:0] exp_q [$];

  function automatic logic [15:0] model_lfsr_step(input logic [15:0] x);
    int fb;
    fb = ((x >> 15) ^ (x >> 13) ^ (x >> 12) ^ (x >> 10)) & 1;
    return 16'(((int'(x) << 1) | fb) & 32'hFFFF);
  endfunction

  function automatic int model_rnd(input logic [15:0] x, input int i);
    int k, v, rot;
    k   = i % 16;
    v   = int'(x);
    rot = ((v << k) | (v >> (16 - k))) & 32'hFFFF;
    return rot % (1 << PW);
  endfunction

  task automatic predict_window();
    logic [NI-1:0] vec;
    int acc [NI];
    for (int i = 0; i < NI; i++) acc[i] = 0;
    for (int s = 0; s < NS; s++) begin
      for (int i = 0; i < NI; i++) begin
`ifdef SPIKE_ENC_DETERMINISTIC_EN
        acc[i] = acc[i] + int'(m_pix[i]);
        vec[i] = (acc[i] >= (1 << PW));
        acc[i] = acc[i] % (1 << PW);
`else
        vec[i] = (model_rnd(m_lfsr, i) < int'(m_pix[i]));
`endif
      end
      m_lfsr = model_lfsr_step(m_lfsr);
      exp_q.push_back(vec);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int            spk_cnt [NI];
  logic [NS-1:0] hist2, hist3;
  int            step_pos = 0;
  logic          prev_sv = 1'b0;

  always @(negedge clk) begin
    logic [NI-1:0] e;
    if (bus.neuron_rst) begin
      step_pos = 0;
      check("nrst_with_first_spike", {30'd0, prev_sv, bus.spike_valid}, 32'd1);
    end
    if (bus.spike_valid) begin
      if (exp_q.size() == 0) check("spike_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("spike_vec", 32'(bus.spike_out), 32'(e));
      end
      for (int i = 0; i < NI; i++) spk_cnt[i] += int'(bus.spike_out[i]);
      if (step_pos < NS) begin
        hist2[step_pos] = bus.spike_out[2];
        hist3[step_pos] = bus.spike_out[3];
        step_pos++;
      end
    end
    prev_sv = bus.spike_valid;
  end

  int   cyc = 0;
  int   xfer_cyc [$];
  logic prev_x1 = 1'b0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (prev_x1) check("n1_idle_to_armed", 32'(state_dbg1), 32'(ST_ARMED));
    prev_x1 = bus1.pixel_valid && bus1.pixel_ready;
    if (prev_x1) xfer_cyc.push_back(cyc);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    m_lfsr = SEED;
    for (int i = 0; i < NI; i++) m_pix[i] = '0;
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_spike_valid", 32'(bus.spike_valid), 32'd0);
    check("rst_pixel_ready", 32'(bus.pixel_ready), 32'd1);
    check("rst_lfsr", 32'(lfsr_dbg), 32'(SEED));
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rst_strobes", {30'd0, bus.neuron_rst, bus.done}, 32'd0);
    tick();
  endtask

  task automatic load_image(input logic [NI*PW-1:0] pix, input bit gaps);
    for (int i = 0; i < NI; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.pixel_valid = 1'b0;
          tick();
        end
      end
      bus.pixel_valid = 1'b1;
      bus.pixel_data  = pix[i*PW +: PW];
      m_pix[i]        = pix[i*PW +: PW];
      @(negedge clk);
      check("ready_in_load", 32'(bus.pixel_ready), 32'd1);
      tick();
    end
    bus.pixel_valid = 1'b0;
  endtask

  // abort_at != 0 resets the DUT at that RUN cycle instead of finishing the window.
  task automatic run_window(input bit hold_valid, input int abort_at);
    @(negedge clk);
    check("armed_state", 32'(state_dbg), 32'(ST_ARMED));
    check("armed_ready", 32'(bus.pixel_ready), 32'd0);
    check("armed_busy", 32'(bus.busy), 32'd1);
    if (hold_valid) bus.pixel_valid = 1'b1;
    bus.pixel_data = PW'($urandom);
    tick();
    repeat ($urandom_range(0, 3)) begin
      bus.pixel_data = PW'($urandom);
      tick();
    end
    bus.start = 1'b1;
    predict_window();
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= NS + 2; c++) begin
      if (hold_valid) bus.pixel_data = PW'($urandom);
      @(negedge clk);
      check("neuron_rst_timing", 32'(bus.neuron_rst), 32'(c == 1));
      check("spike_valid_timing", 32'(bus.spike_valid), 32'(c <= NS));
      check("done_timing", 32'(bus.done), 32'(c == NS + 1));
      check("busy_timing", 32'(bus.busy), 32'(c <= NS + 1));
      if (c == NS + 1) begin
        check("done_spike_out_zero", 32'(bus.spike_out), 32'd0);
        bus.pixel_valid = 1'b0;
      end
      if (c == NS + 2) check("ready_after_done", 32'(bus.pixel_ready), 32'd1);
      tick();
      if (c == abort_at) begin
        bus.pixel_valid = 1'b0;
        do_reset();
        return;
      end
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NI; i++) spk_cnt[i] = 0;
  endtask

  // ---------------- main sequence ----------------
  localparam logic [NI*PW-1:0] IMG_A = {8'd64, 8'd128, 8'd255, 8'd0};

  initial begin
    logic [NI*PW-1:0] img;
    rst = 1'b1;
    bus.pixel_valid = 1'b0; bus.pixel_data = '0; bus.start = 1'b0;
    bus1.pixel_valid = 1'b0; bus1.pixel_data = '0; bus1.start = 1'b0;
    clear_counts();
    repeat (2) tick();
    do_reset();

    // start while IDLE must do nothing
    bus.start = 1'b1;
    repeat (3) tick();
    bus.start = 1'b0;
    @(negedge clk);
    check("idle_start_busy", 32'(bus.busy), 32'd0);
    check("idle_start_state", 32'(state_dbg), 32'(ST_IDLE));
    tick();

    // directed image
    clear_counts();
    load_image(IMG_A, 1'b0);
    run_window(1'b0, 0);
    check("pix0_never_spikes", 32'(spk_cnt[0]), 32'd0);
`ifdef SPIKE_ENC_DETERMINISTIC_EN
    check("det_cnt1", 32'(spk_cnt[1]), 32'd15);
    check("det_cnt2", 32'(spk_cnt[2]), 32'd8);
    check("det_cnt3", 32'(spk_cnt[3]), 32'd4);
    check("det_steps_in2", 32'(hist2), 32'h0000AAAA);
    check("det_steps_in3", 32'(hist3), 32'h00008888);
`endif

    // back-pressure, then replay of the same image from reset
    img = NI*PW'($urandom);
    do_reset();
    load_image(img, 1'b1);
    run_window(1'b1, 0);
    do_reset();
    load_image(img, 1'b0);
    run_window(1'b0, 0);

    // reset in the middle of RUN, then a normal window
    load_image(NI*PW'($urandom), 1'b1);
    run_window(1'b0, $urandom_range(2, NS - 2));
    for (int n = 0; n < 8; n++) begin
      load_image(NI*PW'($urandom), 1'b1);
      run_window(1'b0, 0);
    end

    // rate statistics over 64 windows
    clear_counts();
    for (int n = 0; n < 64; n++) begin
      load_image(IMG_A, 1'b0);
      run_window(1'b0, 0);
    end
    check("stat_in0_zero", 32'(spk_cnt[0]), 32'd0);
`ifdef SPIKE_ENC_DETERMINISTIC_EN
    check("stat_in1_det", 32'(spk_cnt[1]), 32'd960);
    check("stat_in2_det", 32'(spk_cnt[2]), 32'd512);
`else
    check("stat_in2_band", 32'(spk_cnt[2] >= 448 && spk_cnt[2] <= 576), 32'd1);
    check("stat_in1_95pct", 32'(spk_cnt[1] >= 973), 32'd1);
`endif

    // NUM_INPUTS=1 back-to-back: valid and start tied high
    xfer_cyc.delete();
    bus1.pixel_valid = 1'b1;
    bus1.start = 1'b1;
    for (int n = 0; n < 70; n++) begin
      bus1.pixel_data = PW'($urandom);
      tick();
    end
    bus1.pixel_valid = 1'b0;
    bus1.start = 1'b0;
    check("n1_transfer_count", 32'(xfer_cyc.size() >= 3), 32'd1);
    for (int k = 1; k < xfer_cyc.size(); k++)
      check("n1_image_period", 32'(xfer_cyc[k] - xfer_cyc[k-1]), 32'd19);

    repeat (3) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
